// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8-bit UART receiver, LSB first, optional odd parity, 1 stop bit.
//             Mid-bit sampling after a 2-FF synchronizer; one-cycle strobe.
//  Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter int PARITY        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] dout,
    output logic       data_strobe,
    output logic       rx_busy,
    output logic       parity_error,
    output logic       framing_error
);

    localparam int c_BIT_CYCLES  = CLK_FREQUENCY / BAUD_RATE;
    localparam int c_HALF_CYCLES = c_BIT_CYCLES / 2;
    localparam int c_TIMER_W     = (c_BIT_CYCLES > 1) ? $clog2(c_BIT_CYCLES) : 1;

    localparam logic [c_TIMER_W-1:0] c_HALF_LAST = c_TIMER_W'(c_HALF_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_BIT_LAST  = c_TIMER_W'(c_BIT_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE = c_TIMER_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_sync1;
    logic                   r_rx_s;
    logic                   r_rx_d;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par_bit;
    logic [7:0]             r_dout;
    logic                   r_strobe;
    logic                   r_busy;
    logic                   r_parity_error;
    logic                   r_framing_error;

    logic                   w_half_hit;
    logic                   w_bit_hit;
    logic                   w_timer_clr;
    logic                   w_shift_en;
    logic                   w_par_en;
    logic                   w_frame_done;
    logic                   w_parity_bad;

    // Synchronizer plus one extra stage for falling-edge detection; all idle high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_half_hit = (r_timer == c_HALF_LAST);
    assign w_bit_hit  = (r_timer == c_BIT_LAST);

    always_comb begin
        w_state_next = r_state;
        w_timer_clr  = 1'b0;
        w_shift_en   = 1'b0;
        w_par_en     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_clr = 1'b1;
                if (r_rx_d && !r_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // A high sample at mid-start means the low pulse was a glitch.
                if (w_half_hit) begin
                    w_timer_clr  = 1'b1;
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_hit) begin
                    w_timer_clr = 1'b1;
                    w_shift_en  = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (w_bit_hit) begin
                    w_timer_clr  = 1'b1;
                    w_par_en     = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_hit) begin
                    w_timer_clr  = 1'b1;
                    w_frame_done = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_timer_clr  = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_parity_bad = (PARITY != 0) && !((^r_shift) ^ r_par_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer   <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par_bit <= 1'b0;
        end else begin
            if (w_timer_clr) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_TIMER_ONE;
            end
            if (r_state == S_START) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
            if (w_par_en) begin
                r_par_bit <= r_rx_s;
            end
        end
    end

    // Result registers update together with the strobe and then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout          <= 8'h00;
            r_strobe        <= 1'b0;
            r_busy          <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_strobe <= w_frame_done;
            r_busy   <= (w_state_next != S_IDLE);
            if (w_frame_done) begin
                r_dout          <= r_shift;
                r_framing_error <= ~r_rx_s;
                r_parity_error  <= w_parity_bad;
            end
        end
    end

    assign dout          = r_dout;
    assign data_strobe   = r_strobe;
    assign rx_busy       = r_busy;
    assign parity_error  = r_parity_error;
    assign framing_error = r_framing_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Brief    : Self-checking bench for uart_rx: serial frame generator plus a
//             queue of expected results compared on every data_strobe.
//  Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 50_000;
    localparam int PAR    = 1;
    localparam int BIT    = CLK_HZ / BAUD;
    localparam int HALF   = BIT / 2;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] w_dout;
    logic       w_strobe;
    logic       w_busy;
    logic       w_perr;
    logic       w_ferr;

    int   n_checks  = 0;
    int   n_fails   = 0;
    int   n_strobes = 0;
    int   n_sent    = 0;
    int   cyc       = 0;
    int   lat_start = 0;
    bit   lat_arm   = 1'b0;
    bit   busy_seen = 1'b0;
    exp_t exp_q[$];

    uart_rx #(
        .CLK_FREQUENCY (CLK_HZ),
        .BAUD_RATE     (BAUD),
        .PARITY        (PAR)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .rx_in         (rx_in),
        .dout          (w_dout),
        .data_strobe   (w_strobe),
        .rx_busy       (w_busy),
        .parity_error  (w_perr),
        .framing_error (w_ferr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Result checker: every strobe must match the oldest outstanding frame.
    always @(negedge clk) begin
        exp_t e;
        if (w_busy) busy_seen = 1'b1;
        if (w_strobe) begin
            n_strobes++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_strobe", 32'(w_strobe), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("dout", 32'(w_dout), 32'(e.data));
                check_eq("parity_error", 32'(w_perr), 32'(e.perr));
                check_eq("framing_error", 32'(w_ferr), 32'(e.ferr));
                check_eq("busy_in_strobe", 32'(w_busy), 32'd0);
                if (lat_arm) begin
                    check_eq("latency", 32'(cyc - lat_start), 32'(HALF + (9 + PAR) * BIT + 3));
                    lat_arm = 1'b0;
                end
            end
        end
    end

    // Called just after a rising edge; holds the level for one bit period.
    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par,
                              input logic bad_stop, input int gap, input bit track_lat);
        exp_t e;
        logic p;
        e.data = d;
        e.perr = bad_par;
        e.ferr = bad_stop;
        exp_q.push_back(e);
        n_sent++;
        if (track_lat) begin
            lat_start = cyc;
            lat_arm   = 1'b1;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        p = ~(^d) ^ bad_par;
        drive_bit(p);
        drive_bit(~bad_stop);
        if (bad_stop) begin
            drive_bit(1'b0);
            drive_bit(1'b0);
            drive_bit(1'b1);
        end
        repeat (gap) drive_bit(1'b1);
    endtask

    initial begin
        int s0;
        logic [7:0] d55;
        d55 = 8'h55;

        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_dout", 32'(w_dout), 32'h00);
        check_eq("rst_strobe", 32'(w_strobe), 32'd0);
        check_eq("rst_busy", 32'(w_busy), 32'd0);
        check_eq("rst_perr", 32'(w_perr), 32'd0);
        check_eq("rst_ferr", 32'(w_ferr), 32'd0);
        rst = 1'b0;

        // Idle line
        busy_seen = 1'b0;
        repeat (2000) @(posedge clk);
        #1;
        check_eq("idle_strobes", 32'(n_strobes), 32'd0);
        check_eq("idle_busy_seen", 32'(busy_seen), 32'd0);
        check_eq("idle_dout", 32'(w_dout), 32'h00);

        // Good frame with latency measurement
        send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1);
        check_eq("a5_strobes", 32'(n_strobes), 32'd1);

        // Bad parity, then a clean frame clears the flag
        send_frame(8'h3C, 1'b1, 1'b0, 1, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0, 1, 1'b0);
        check_eq("perr_cleared", 32'(w_perr), 32'd0);

        // Stop bit low, line low for a while: exactly one strobe
        s0 = n_strobes;
        send_frame(8'hFF, 1'b0, 1'b1, 3, 1'b0);
        check_eq("ff_single_strobe", 32'(n_strobes), 32'(s0 + 1));
        check_eq("ff_ferr_held", 32'(w_ferr), 32'd1);

        // Short low glitch on idle line
        s0 = n_strobes;
        busy_seen = 1'b0;
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (3 * BIT) @(posedge clk);
        #1;
        check_eq("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check_eq("glitch_busy_end", 32'(w_busy), 32'd0);
        check_eq("glitch_no_strobe", 32'(n_strobes), 32'(s0));
        check_eq("glitch_ferr_kept", 32'(w_ferr), 32'd1);

        // Reset in the middle of a frame (at data bit 4)
        s0 = n_strobes;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d55[i]);
        rx_in = 1'b1;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_dout", 32'(w_dout), 32'h00);
        check_eq("abort_busy", 32'(w_busy), 32'd0);
        check_eq("abort_ferr", 32'(w_ferr), 32'd0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check_eq("abort_no_strobe", 32'(n_strobes), 32'(s0));
        send_frame(8'h81, 1'b0, 1'b0, 1, 1'b0);

        // Back-to-back, no idle gap
        send_frame(8'h01, 1'b0, 1'b0, 0, 1'b0);
        send_frame(8'h80, 1'b0, 1'b0, 1, 1'b0);

        // Randomized frames
        for (int k = 0; k < 12; k++) begin
            send_frame(8'($urandom_range(0, 255)),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 4) == 0),
                       int'($urandom_range(0, 2)), 1'b0);
        end

        for (int t = 0; t < 20 * BIT && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        check_eq("strobe_total", 32'(n_strobes), 32'(n_sent));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
